// File: rtl/mrd_rdx3_pkg.sv
// mrd_rdx3_pkg: shared constants, complex container type and BFP shift helper
// for the inverse radix-3 butterfly.
package mrd_rdx3_pkg;
  localparam logic signed [17:0] C_SQRT3_2 = 18'sd113512;
  localparam int LATENCY = 4;
  localparam int CW = 24;
  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cplx_t;
  // Free guard bits absorb the radix-3 growth; only the missing ones are shifted out.
  function automatic logic [1:0] shift_calc(input logic [1:0] margin);
    return margin[1] ? 2'd0 : 2'd2 - margin;
  endfunction
endpackage

// File: rtl/mrd_bfp_shift.sv
// mrd_bfp_shift: arithmetic right shift by 0..2 with saturation to WO bits.
// MRD_RDX3_INV_ROUND_EN selects round-half-up instead of floor truncation.
module mrd_bfp_shift #(
  parameter int WI = 24,
  parameter int WO = 18
) (
  input  logic signed [WI-1:0] x,
  input  logic        [1:0]    sh,
  output logic signed [WO-1:0] y
);
  localparam logic signed [WI:0] MX = (WI + 1)'(2 ** (WO - 1) - 1);
  localparam logic signed [WI:0] MN = ~MX;
  logic signed [WI:0] xe, q;
  always_comb begin
`ifdef MRD_RDX3_INV_ROUND_EN
    xe = (WI + 1)'(x) + $signed({{(WI - 1){1'b0}}, sh == 2'd2, sh == 2'd1});
`else
    xe = (WI + 1)'(x);
`endif
    q = xe >>> sh;
    y = q > MX ? MX[WO-1:0] : q < MN ? MN[WO-1:0] : q[WO-1:0];
  end
endmodule

// File: rtl/mrd_rdx3_inv.sv
// mrd_rdx3_inv: 4-stage inverse radix-3 butterfly with BFP exponent tracking.
// Define MRD_RDX3_INV_ROUND_EN for round-half-up in the output shift (default: truncate).
module mrd_rdx3_inv
  import mrd_rdx3_pkg::*;
#(
  parameter int wDataInOut = 18,
  parameter int wExp = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_val,
  input  logic [0:4][wDataInOut-1:0]   din_real,
  input  logic [0:4][wDataInOut-1:0]   din_imag,
  input  logic [1:0]                   margin_in,
  input  logic [wExp-1:0]              exp_in,
  output logic                         out_val,
  output logic [0:4][wDataInOut-1:0]   dout_real,
  output logic [0:4][wDataInOut-1:0]   dout_imag,
  output logic [wExp-1:0]              exp_out
);
  localparam int W = wDataInOut;
  localparam int PW = W + 19;
  logic [LATENCY-1:0] v;
  logic signed [W-1:0] ain[2], bin[2], cin[2], a1[2], a2[2];
  logic signed [W:0] s1[2], d1[2], s2[2], h2[2], m2[2];
  logic signed [PW-1:0] p[2];
  logic [1:0] sh, sh1, sh2, sh3;
  logic [wExp:0] esum;
  logic [wExp-1:0] e1, e2, e3;
  cplx_t x3[3];
  logic signed [W-1:0] y_re[3], y_im[3];
  logic unused_lanes;
  assign unused_lanes = ^{din_real[3:4], din_imag[3:4]};
  assign ain = '{din_real[0], din_imag[0]};
  assign bin = '{din_real[1], din_imag[1]};
  assign cin = '{din_real[2], din_imag[2]};
  assign sh = shift_calc(margin_in);
  assign esum = {1'b0, exp_in} + {{(wExp - 1){1'b0}}, sh};
  assign out_val = v[LATENCY-1];
  always_comb begin
    for (int k = 0; k < 2; k++) p[k] = PW'(d1[k]) * PW'(C_SQRT3_2);
  end
  always_ff @(posedge clk) v <= !rst_n ? '0 : {v[LATENCY-2:0], in_val};
  // Data path carries no reset; the valid chain alone decides what is emitted.
  always_ff @(posedge clk) begin
    if (in_val) begin
      for (int k = 0; k < 2; k++) begin
        a1[k] <= ain[k];
        s1[k] <= (W + 1)'(bin[k]) + (W + 1)'(cin[k]);
        d1[k] <= (W + 1)'(bin[k]) - (W + 1)'(cin[k]);
      end
      sh1 <= sh;
      e1 <= esum[wExp] ? '1 : esum[wExp-1:0];
    end
    if (v[0]) begin
      for (int k = 0; k < 2; k++) begin
        a2[k] <= a1[k];
        s2[k] <= s1[k];
        h2[k] <= s1[k] >>> 1;
        m2[k] <= (W + 1)'((p[k] + PW'(65536)) >>> 17);
      end
      sh2 <= sh1;
      e2 <= e1;
    end
    if (v[1]) begin
      x3[0].re <= CW'(a2[0]) + CW'(s2[0]);
      x3[0].im <= CW'(a2[1]) + CW'(s2[1]);
      x3[1].re <= CW'(a2[0]) - CW'(h2[0]) - CW'(m2[1]);
      x3[1].im <= CW'(a2[1]) - CW'(h2[1]) + CW'(m2[0]);
      x3[2].re <= CW'(a2[0]) - CW'(h2[0]) + CW'(m2[1]);
      x3[2].im <= CW'(a2[1]) - CW'(h2[1]) - CW'(m2[0]);
      sh3 <= sh2;
      e3 <= e2;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_sh
    mrd_bfp_shift #(.WI(CW), .WO(W)) u_re (.x(x3[i].re), .sh(sh3), .y(y_re[i]));
    mrd_bfp_shift #(.WI(CW), .WO(W)) u_im (.x(x3[i].im), .sh(sh3), .y(y_im[i]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_real <= '0;
      dout_imag <= '0;
      exp_out <= '0;
    end else if (v[LATENCY-2]) begin
      dout_real <= {y_re[0], y_re[1], y_re[2], (2 * W)'(0)};
      dout_imag <= {y_im[0], y_im[1], y_im[2], (2 * W)'(0)};
      exp_out <= e3;
    end
  end
endmodule

// File: tb/tb_mrd_rdx3_inv.sv
// tb_mrd_rdx3_inv: directed and random vectors against an arithmetic IDFT-3 model.
module tb_mrd_rdx3_inv;
  localparam int W = 18;
  logic clk = 0, rst_n = 0, in_val = 0;
  logic [0:4][W-1:0] din_real = '0, din_imag = '0;
  logic [1:0] margin_in = '0;
  logic [3:0] exp_in = '0;
  logic out_val;
  logic [0:4][W-1:0] dout_real, dout_imag;
  logic [3:0] exp_out;
  int checks = 0, errors = 0;
  typedef struct { bit v; longint o[6]; longint e; } ent_t;
  ent_t pipe[$];
  ent_t last;

  mrd_rdx3_inv dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .din_real(din_real), .din_imag(din_imag),
    .margin_in(margin_in), .exp_in(exp_in), .out_val(out_val), .dout_real(dout_real),
    .dout_imag(dout_imag), .exp_out(exp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint scale(input longint x, input int sh);
    longint q;
`ifdef MRD_RDX3_INV_ROUND_EN
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
`endif
    q = x >>> sh;
    return q > 131071 ? 131071 : q < -131072 ? -131072 : q;
  endfunction

  function automatic ent_t model();
    ent_t e;
    longint a[2], b[2], c[2], s[2], d[2], h[2], m[2], x[6];
    int sh;
    a = '{longint'($signed(din_real[0])), longint'($signed(din_imag[0]))};
    b = '{longint'($signed(din_real[1])), longint'($signed(din_imag[1]))};
    c = '{longint'($signed(din_real[2])), longint'($signed(din_imag[2]))};
    for (int k = 0; k < 2; k++) begin
      s[k] = b[k] + c[k];
      d[k] = b[k] - c[k];
      h[k] = s[k] >>> 1;
      m[k] = (d[k] * 113512 + 65536) >>> 17;
    end
    x = '{a[0] + s[0], a[1] + s[1],
          a[0] - h[0] - m[1], a[1] - h[1] + m[0],
          a[0] - h[0] + m[1], a[1] - h[1] - m[0]};
    sh = margin_in >= 2 ? 0 : 2 - int'(margin_in);
    for (int k = 0; k < 6; k++) e.o[k] = scale(x[k], sh);
    e.e = (int'(exp_in) + sh > 15) ? 15 : int'(exp_in) + sh;
    e.v = 1;
    return e;
  endfunction

  task automatic cycle();
    ent_t n, e;
    @(posedge clk);
    if (!rst_n) begin
      pipe.delete();
      last.v = 0;
      last.o = '{default: 0};
      last.e = 0;
    end else begin
      if (in_val) n = model(); else n.v = 0;
      pipe.push_back(n);
    end
    #1;
    if (pipe.size() == 4) e = pipe.pop_front(); else e.v = 0;
    chk("out_val", out_val, e.v);
    if (e.v) last = e;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("re%0d", k), $signed(dout_real[k]), last.o[2*k]);
      chk($sformatf("im%0d", k), $signed(dout_imag[k]), last.o[2*k+1]);
    end
    chk("re34", {dout_real[3], dout_real[4]}, 0);
    chk("im34", {dout_imag[3], dout_imag[4]}, 0);
    chk("exp_out", exp_out, last.e);
  endtask

  task automatic junk_hi();
    din_real[3] = W'($urandom); din_real[4] = W'($urandom);
    din_imag[3] = W'($urandom); din_imag[4] = W'($urandom);
  endtask

  task automatic send(input longint ar, ai, br, bi, cr, ci, input int mg, ex);
    in_val = 1;
    din_real[0] = W'(ar); din_imag[0] = W'(ai);
    din_real[1] = W'(br); din_imag[1] = W'(bi);
    din_real[2] = W'(cr); din_imag[2] = W'(ci);
    junk_hi();
    margin_in = 2'(mg);
    exp_in = 4'(ex);
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_val = 0;
      din_real = {W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
      din_imag = {W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
      margin_in = 2'($urandom);
      exp_in = 4'($urandom);
      cycle();
    end
  endtask

  function automatic longint rv();
    int sel;
    sel = $urandom_range(0, 9);
    return sel == 0 ? 131071 : sel == 1 ? -131072 : longint'($signed(18'($urandom)));
  endfunction

  initial begin
    idle(3);
    rst_n = 1;
    idle(2);
    send(131071, 0, 131071, 0, 131071, 0, 0, 3);
    idle(5);
    send(1000, 0, 0, 0, 0, 0, 2, 7);
    idle(5);
    send(0, 0, 1000, 0, 0, 0, 2, 0);
    idle(5);
    send(1000, 0, 0, 0, 0, 0, 2, 7);
    send(0, 0, 1000, 0, 0, 0, 2, 0);
    send(131071, 0, 131071, 0, 131071, 0, 0, 3);
    idle(6);
    send(0, 0, 1000, 0, 0, 0, 2, 0);
    idle(1);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(6);
    send(-131072, 0, -131072, 0, -131072, 0, 0, 15);
    idle(5);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        idle(1);
        rst_n = 1;
      end else if ($urandom_range(0, 3) != 0)
        send(rv(), rv(), rv(), rv(), rv(), rv(), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        idle(1);
    end
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
